// File: rtl/conway_ctrl_pkg.sv
// Shared definitions for the Game-of-Life sweep controller: FSM encoding,
// bank count and the (y phase, x phase) -> bank mapping.
package conway_ctrl_pkg;

  localparam int NUM_BANKS = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } state_t;

  // Bank holding a cell whose coordinates are at (y phase, x phase) inside
  // its 3x3 block: y_phase*3 + x_phase, built from shifts and adds.
  function automatic logic [3:0] bank_idx(input logic [1:0] y_phase,
                                          input logic [1:0] x_phase);
    logic [3:0] yp;
    yp = {2'b00, y_phase};
    return (yp << 1) + yp + {2'b00, x_phase};
  endfunction

endpackage

// File: rtl/conway_sweep_ctrl_if.sv
// Control/status and bank-strobe bundle between the sweep controller and
// the 9-bank datapath.
//
// Handshake: start is a level sampled on each rising edge while the
// controller is idle (busy=0); a high sample launches exactly one
// generation and is ignored whenever busy=1. run_continuous, while high,
// chains generations back to back. done is a one-cycle pulse marking the
// end of each generation, in the same cycle generation and
// frame_buffer_select take their new values. There is no back-pressure:
// every asserted read_enable/write_enable strobe is consumed that cycle.
interface conway_sweep_ctrl_if
  import conway_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int GEN_WIDTH  = 16
);
  logic                  start;
  logic                  run_continuous;
  logic                  busy;
  logic                  done;
  logic [GEN_WIDTH-1:0]  generation;
  logic                  frame_buffer_select;
  logic [8:0]            read_enable;
  logic [8:0]            write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] read_addr_0, read_addr_1, read_addr_2;
  logic [ADDR_WIDTH-1:0] read_addr_3, read_addr_4, read_addr_5;
  logic [ADDR_WIDTH-1:0] read_addr_6, read_addr_7, read_addr_8;
  state_t                state_dbg;

  modport master (
    input  start, run_continuous,
    output busy, done, generation, frame_buffer_select,
    output read_enable, write_enable, write_addr,
    output read_addr_0, read_addr_1, read_addr_2,
    output read_addr_3, read_addr_4, read_addr_5,
    output read_addr_6, read_addr_7, read_addr_8,
    output state_dbg
  );

  modport slave (
    output start, run_continuous,
    input  busy, done, generation, frame_buffer_select,
    input  read_enable, write_enable, write_addr,
    input  read_addr_0, read_addr_1, read_addr_2,
    input  read_addr_3, read_addr_4, read_addr_5,
    input  read_addr_6, read_addr_7, read_addr_8,
    input  state_dbg
  );
endinterface

// File: rtl/conway_neighbor_addr.sv
// Combinational neighbourhood address generator: from the centre cell's
// phase/block coordinates, produce the read address for each of the 9
// banks (toroidal wrap) plus the centre's own bank and address.
module conway_neighbor_addr
  import conway_ctrl_pkg::*;
#(
  parameter int WIDTH_BLOCKS  = 2,
  parameter int HEIGHT_BLOCKS = 2,
  parameter int ADDR_WIDTH    = 2
) (
  input  logic [1:0]                            x_phase,
  input  logic [1:0]                            y_phase,
  input  logic [ADDR_WIDTH-1:0]                 x_block,
  input  logic [ADDR_WIDTH-1:0]                 y_block,
  output logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0]  read_addr,
  output logic [3:0]                            centre_bank,
  output logic [ADDR_WIDTH-1:0]                 centre_addr
);

  localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(WIDTH_BLOCKS - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST = ADDR_WIDTH'(HEIGHT_BLOCKS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

  // Index 0/1/2 = offset -1/0/+1 along that axis.
  logic [1:0]            nx_p [3];
  logic [1:0]            ny_p [3];
  logic [ADDR_WIDTH-1:0] nx_b [3];
  logic [ADDR_WIDTH-1:0] ny_b [3];

  function automatic logic [ADDR_WIDTH-1:0] blk_addr(input logic [ADDR_WIDTH-1:0] yb,
                                                     input logic [ADDR_WIDTH-1:0] xb);
    return ADDR_WIDTH'(int'(yb) * WIDTH_BLOCKS + int'(xb));
  endfunction

  // Neighbour coordinates along each axis, wrapping across block and grid edges.
  always_comb begin
    nx_p[1] = x_phase;
    nx_b[1] = x_block;
    ny_p[1] = y_phase;
    ny_b[1] = y_block;
    if (x_phase == 2'd0) begin
      nx_p[0] = 2'd2;
      nx_b[0] = (x_block == '0) ? X_LAST : x_block - ONE;
    end else begin
      nx_p[0] = x_phase - 2'd1;
      nx_b[0] = x_block;
    end
    if (x_phase == 2'd2) begin
      nx_p[2] = 2'd0;
      nx_b[2] = (x_block == X_LAST) ? '0 : x_block + ONE;
    end else begin
      nx_p[2] = x_phase + 2'd1;
      nx_b[2] = x_block;
    end
    if (y_phase == 2'd0) begin
      ny_p[0] = 2'd2;
      ny_b[0] = (y_block == '0) ? Y_LAST : y_block - ONE;
    end else begin
      ny_p[0] = y_phase - 2'd1;
      ny_b[0] = y_block;
    end
    if (y_phase == 2'd2) begin
      ny_p[2] = 2'd0;
      ny_b[2] = (y_block == Y_LAST) ? '0 : y_block + ONE;
    end else begin
      ny_p[2] = y_phase + 2'd1;
      ny_b[2] = y_block;
    end
  end

  // Scatter the 9 neighbour addresses onto their banks; the 3x3 window
  // always covers every phase pair once, so each bank is written exactly once.
  always_comb begin
    read_addr = '0;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) begin
        read_addr[bank_idx(ny_p[j], nx_p[i])] = blk_addr(ny_b[j], nx_b[i]);
      end
    end
  end

  assign centre_bank = bank_idx(y_phase, x_phase);
  assign centre_addr = blk_addr(y_block, x_block);

endmodule

// File: rtl/conway_sweep_ctrl.sv
// Sequences one Game-of-Life generation: raster sweep issuing 9-bank reads
// per cell, a delayed single-bank write per cell, drain, then buffer swap.
module conway_sweep_ctrl
  import conway_ctrl_pkg::*;
#(
  parameter int WIDTH_BLOCKS  = 2,
  parameter int HEIGHT_BLOCKS = 2,
  parameter int ADDR_WIDTH    = 2,
  parameter int WRITE_LATENCY = 1,
  parameter int GEN_WIDTH     = 16
) (
  input logic                clk,
  input logic                reset,
  conway_sweep_ctrl_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] X_LAST     = ADDR_WIDTH'(WIDTH_BLOCKS - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST     = ADDR_WIDTH'(HEIGHT_BLOCKS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
  localparam logic [2:0]            DRAIN_LAST = 3'(WRITE_LATENCY - 1);

  state_t state, state_next;

  logic [1:0]            x_phase, y_phase;
  logic [ADDR_WIDTH-1:0] x_block, y_block;
  logic [2:0]            drain_cnt;
  logic                  sweeping, x_last, y_last;

  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] ra;
  logic [3:0]                           centre_bank;
  logic [ADDR_WIDTH-1:0]                centre_addr;

  logic                  wp_valid [WRITE_LATENCY];
  logic [3:0]            wp_bank  [WRITE_LATENCY];
  logic [ADDR_WIDTH-1:0] wp_addr  [WRITE_LATENCY];

  logic [GEN_WIDTH-1:0]  generation_q;
  logic                  select_q;
  logic                  done_q;

  assign sweeping = (state == SWEEP);
  assign x_last   = (x_phase == 2'd2) && (x_block == X_LAST);
  assign y_last   = (y_phase == 2'd2) && (y_block == Y_LAST);

  conway_neighbor_addr #(
    .WIDTH_BLOCKS (WIDTH_BLOCKS),
    .HEIGHT_BLOCKS(HEIGHT_BLOCKS),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_neighbor_addr (
    .x_phase    (x_phase),
    .y_phase    (y_phase),
    .x_block    (x_block),
    .y_block    (y_block),
    .read_addr  (ra),
    .centre_bank(centre_bank),
    .centre_addr(centre_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: sweep all cells, drain the write pipe, swap, then repeat or idle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (bus.start || bus.run_continuous) state_next = SWEEP;
      SWEEP: if (x_last && y_last)                state_next = DRAIN;
      DRAIN: if (drain_cnt == DRAIN_LAST)         state_next = SWAP;
      SWAP:  state_next = bus.run_continuous ? SWEEP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cell coordinates: held at (0,0) outside SWEEP, raster-advanced inside it.
  always_ff @(posedge clk) begin
    if (reset || !sweeping) begin
      x_phase <= 2'd0;
      x_block <= '0;
      y_phase <= 2'd0;
      y_block <= '0;
    end else if (x_phase != 2'd2) begin
      x_phase <= x_phase + 2'd1;
    end else begin
      x_phase <= 2'd0;
      if (x_block != X_LAST) begin
        x_block <= x_block + ONE;
      end else begin
        x_block <= '0;
        if (y_phase != 2'd2) begin
          y_phase <= y_phase + 2'd1;
        end else begin
          y_phase <= 2'd0;
          y_block <= (y_block == Y_LAST) ? '0 : y_block + ONE;
        end
      end
    end
  end

  // Counts DRAIN cycles so the last pending write retires before SWAP.
  always_ff @(posedge clk) begin
    if (reset || state != DRAIN) drain_cnt <= 3'd0;
    else                         drain_cnt <= drain_cnt + 3'd1;
  end

  // Write pipeline: each issued cell's bank/address emerges WRITE_LATENCY cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WRITE_LATENCY; i++) begin
        wp_valid[i] <= 1'b0;
        wp_bank[i]  <= 4'd0;
        wp_addr[i]  <= '0;
      end
    end else begin
      wp_valid[0] <= sweeping;
      wp_bank[0]  <= sweeping ? centre_bank : 4'd0;
      wp_addr[0]  <= sweeping ? centre_addr : '0;
      for (int i = 1; i < WRITE_LATENCY; i++) begin
        wp_valid[i] <= wp_valid[i-1];
        wp_bank[i]  <= wp_bank[i-1];
        wp_addr[i]  <= wp_addr[i-1];
      end
    end
  end

  // Generation bookkeeping updated on the closing edge of SWAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      generation_q <= '0;
      select_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= (state == SWAP);
      if (state == SWAP) begin
        generation_q <= generation_q + GEN_WIDTH'(1);
        select_q     <= ~select_q;
      end
    end
  end

  // Outputs: read strobes/addresses only while sweeping, write strobe from the pipe tail.
  always_comb begin
    bus.busy                = (state != IDLE);
    bus.done                = done_q;
    bus.generation          = generation_q;
    bus.frame_buffer_select = select_q;
    bus.state_dbg           = state;
    bus.read_enable         = sweeping ? 9'h1FF : 9'h000;
    bus.read_addr_0         = sweeping ? ra[0] : '0;
    bus.read_addr_1         = sweeping ? ra[1] : '0;
    bus.read_addr_2         = sweeping ? ra[2] : '0;
    bus.read_addr_3         = sweeping ? ra[3] : '0;
    bus.read_addr_4         = sweeping ? ra[4] : '0;
    bus.read_addr_5         = sweeping ? ra[5] : '0;
    bus.read_addr_6         = sweeping ? ra[6] : '0;
    bus.read_addr_7         = sweeping ? ra[7] : '0;
    bus.read_addr_8         = sweeping ? ra[8] : '0;
    bus.write_enable        = wp_valid[WRITE_LATENCY-1] ? (9'b1 << wp_bank[WRITE_LATENCY-1]) : 9'h000;
    bus.write_addr          = wp_valid[WRITE_LATENCY-1] ? wp_addr[WRITE_LATENCY-1] : '0;
  end

endmodule

// File: tb/tb_conway_sweep_ctrl.sv
// Bench for conway_sweep_ctrl: two configurations (WRITE_LATENCY=1/GEN_WIDTH=16
// and WRITE_LATENCY=3/GEN_WIDTH=2) share one stimulus stream and are each
// compared every cycle against a schedule model derived from cell coordinates.
module tb_conway_sweep_ctrl;

  localparam int WB = 2;
  localparam int HB = 2;
  localparam int W  = 3 * WB;
  localparam int H  = 3 * HB;
  localparam int N  = W * H;

  logic clk;
  logic reset;
  logic start;
  logic run_continuous;

  int n_vec = 0;
  int n_err = 0;

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int L  = (g == 0) ? 1 : 3;
    localparam int GW = (g == 0) ? 16 : 2;
    localparam int P  = N + L + 1;

    conway_sweep_ctrl_if #(.ADDR_WIDTH(2), .GEN_WIDTH(GW)) bus ();

    assign bus.start          = start;
    assign bus.run_continuous = run_continuous;

    conway_sweep_ctrl #(
      .WIDTH_BLOCKS (WB),
      .HEIGHT_BLOCKS(HB),
      .ADDR_WIDTH   (2),
      .WRITE_LATENCY(L),
      .GEN_WIDTH    (GW)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );

    // Reference: a generation is P cycles; cycle k<N reads cell k, cycle
    // k in [L, N+L) writes cell k-L, cycle P-1 is the swap.
    bit m_active = 1'b0;
    bit m_sel    = 1'b0;
    bit m_done   = 1'b0;
    int m_k      = 0;
    int m_gen    = 0;

    always @(posedge clk) begin
      if (reset) begin
        m_active = 1'b0;
        m_sel    = 1'b0;
        m_done   = 1'b0;
        m_k      = 0;
        m_gen    = 0;
      end else begin
        m_done = 1'b0;
        if (m_active) begin
          if (m_k == P - 1) begin
            m_gen  = (m_gen + 1) % (1 << GW);
            m_sel  = !m_sel;
            m_done = 1'b1;
            if (run_continuous) m_k = 0;
            else                m_active = 1'b0;
          end else begin
            m_k++;
          end
        end else if (start || run_continuous) begin
          m_active = 1'b1;
          m_k      = 0;
        end
      end
    end

    always @(negedge clk) begin
      logic [17:0] exp_ra, got_ra;
      logic [8:0]  exp_re, exp_we;
      logic [1:0]  exp_wa;
      int cx, cy, nx, ny, b, a, c;
      exp_ra = '0;
      exp_re = '0;
      exp_we = '0;
      exp_wa = '0;
      if (m_active && m_k < N) begin
        exp_re = 9'h1FF;
        cx = m_k % W;
        cy = m_k / W;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            nx = (cx + dx + W) % W;
            ny = (cy + dy + H) % H;
            b  = (ny % 3) * 3 + (nx % 3);
            a  = (ny / 3) * WB + (nx / 3);
            exp_ra[b*2 +: 2] = 2'(a);
          end
        end
      end
      if (m_active && m_k >= L && m_k < N + L) begin
        c  = m_k - L;
        cx = c % W;
        cy = c / W;
        b  = (cy % 3) * 3 + (cx % 3);
        a  = (cy / 3) * WB + (cx / 3);
        exp_we = 9'(1) << b;
        exp_wa = 2'(a);
      end
      got_ra = {bus.read_addr_8, bus.read_addr_7, bus.read_addr_6,
                bus.read_addr_5, bus.read_addr_4, bus.read_addr_3,
                bus.read_addr_2, bus.read_addr_1, bus.read_addr_0};
      check($sformatf("busy L%0d", L),         64'(bus.busy),                64'(m_active));
      check($sformatf("done L%0d", L),         64'(bus.done),                64'(m_done));
      check($sformatf("generation L%0d", L),   64'(bus.generation),          64'(m_gen));
      check($sformatf("fb_select L%0d", L),    64'(bus.frame_buffer_select), 64'(m_sel));
      check($sformatf("read_enable L%0d", L),  64'(bus.read_enable),         64'(exp_re));
      check($sformatf("read_addr L%0d", L),    64'(got_ra),                  64'(exp_ra));
      check($sformatf("write_enable L%0d", L), 64'(bus.write_enable),        64'(exp_we));
      check($sformatf("write_addr L%0d", L),   64'(bus.write_addr),          64'(exp_wa));
    end
  end

  // Driver: one call = one clock cycle of input values.
  task automatic drive(input bit s, input bit r, input bit rs);
    @(negedge clk);
    #2;
    start          = s;
    run_continuous = r;
    reset          = rs;
  endtask

  initial begin
    bit rc;
    start          = 1'b0;
    run_continuous = 1'b0;
    reset          = 1'b1;
    repeat (3) drive(0, 0, 1);
    drive(0, 0, 0);

    // Single step with a start pulse landing while busy.
    drive(1, 0, 0);
    repeat (4) drive(0, 0, 0);
    drive(1, 0, 0);
    repeat (45) drive(0, 0, 0);

    // Free-running with start asserted at entry; long enough for GEN_WIDTH=2 wrap.
    drive(1, 1, 0);
    repeat (260) drive(1'($urandom_range(0, 3) == 0), 1, 0);
    repeat (50) drive(0, 0, 0);

    // Reset mid-generation.
    drive(1, 0, 0);
    repeat (9) drive(0, 0, 0);
    drive(0, 0, 1);
    repeat (10) drive(0, 0, 0);

    // Randomized mix of start, run_continuous and occasional reset.
    rc = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 99) == 0) rc = !rc;
      drive(1'($urandom_range(0, 15) == 0), rc, 1'($urandom_range(0, 499) == 0));
    end
    repeat (50) drive(0, 0, 0);

    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conway_sweep_ctrl.md
Name: conway_sweep_ctrl

Overview:
Sequences one Game-of-Life generation over the 9-bank, double-buffered cell store and update datapath (data_path).
- Issues one centre cell per cycle in raster order: all 9 bank reads for its 3x3 toroidal neighbourhood, then the delayed single-bank write of the new state.
- Toggles frame_buffer_select between generations.
- Runs single-step (start) or free-running (run_continuous).

Parameters:
WIDTH_BLOCKS, 2, grid width in 3-cell blocks; grid width W = 3*WIDTH_BLOCKS
HEIGHT_BLOCKS, 2, grid height in 3-cell blocks; H = 3*HEIGHT_BLOCKS
ADDR_WIDTH, 2, bank address width; must satisfy 2^ADDR_WIDTH >= WIDTH_BLOCKS*HEIGHT_BLOCKS
WRITE_LATENCY, 1, cycles from read issue to write strobe for the same cell; legal 1..4
GEN_WIDTH, 16, generation counter width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request for one generation; ignored while busy
run_continuous  input  1  while high, generations run back to back
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at generation completion
generation  output  GEN_WIDTH  completed-generation count
frame_buffer_select  output  1  selects read/write buffer roles in data_path
read_enable  output  9  per-bank read strobe
write_enable  output  9  one-hot per-bank write strobe
write_addr  output  ADDR_WIDTH  address for the enabled write bank
read_addr_0 .. read_addr_8  output  ADDR_WIDTH each  per-bank read address

Behaviour:
- Mapping: cell (x,y) lives in bank b = (y mod 3)*3 + (x mod 3) at address a = (y div 3)*WIDTH_BLOCKS + (x div 3).
- Coordinates are held as phase (0..2) and block counters. No dividers or modulo operators.
- Reset: state=IDLE; busy=0, done=0, generation=0, frame_buffer_select=0, read_enable=0, write_enable=0, all addresses 0; write pipeline flushed.
- IDLE: leave on start or run_continuous → SWEEP, with x=y=0.
- SWEEP: one cell per cycle.
  - read_enable=9'h1FF.
  - For each of the 9 neighbours (x+dx, y+dy), dx,dy in {-1,0,1}: wrap toroidally, then drive read_addr_b of that neighbour's bank with its address. All 9 banks are distinct by construction.
  - x advances; at x=W-1, x wraps to 0 and y increments.
  - After issuing cell (W-1,H-1) → DRAIN.
- Write pipeline: a WRITE_LATENCY-deep shift register of {valid, centre bank, centre addr}.
  - write_enable = onehot(bank) when valid, else 0; write_addr = addr.
  - Exactly one write per issued cell, WRITE_LATENCY cycles after its read.
- DRAIN: WRITE_LATENCY cycles; read_enable=0; pending writes retire → SWAP.
- SWAP: one cycle, no strobes.
  - On its closing edge: frame_buffer_select inverts, generation increments (wraps at 2^GEN_WIDTH), done is set for exactly one cycle.
  - Next state: SWEEP if run_continuous=1, else IDLE.
- Period: W*H + WRITE_LATENCY + 1 cycles per generation.
- start while busy: ignored, not queued. start and run_continuous together in IDLE: one entry only.
- Dropping run_continuous mid-generation: the current generation completes, then IDLE.
- reset mid-operation: reset values on the next cycle; in-flight writes are discarded and no further strobes are issued.

Decomposition:
- Package conway_ctrl_pkg: state encoding (IDLE, SWEEP, DRAIN, SWAP), bank-index function from (y phase, x phase), constant NUM_BANKS=9.
- Sub-module conway_neighbor_addr (combinational):
  - Inputs: x/y phase and block counters.
  - Outputs: the 9 per-bank read addresses and the centre bank/addr, with wrap handling at x=0, x=W-1, y=0 and y=H-1.

Test Plan:
1. Defaults; reset, start sampled at edge T-1 → read_enable=1FF for cycles T..T+35; write_enable=9'b000000001, write_addr=0 at T+1; read_enable=0 at T+36 (DRAIN, last write); SWAP at T+37; done=1, frame_buffer_select=1, generation=1 visible at T+38; busy=0 after.
2. Centre (0,0), wrap corner → read_addr_0..8 = 0,0,1,0,0,1,2,2,3.
3. Centre (4,3) → read_addr_0..5=3, read_addr_6..8=1; next cycle write_enable=9'b000000010, write_addr=3.
4. run_continuous=1 for 3 generations → done pulses 38 cycles apart; generation 1,2,3; frame_buffer_select 1,0,1; deassert during gen 3 → IDLE after its done.
5. start pulsed at T+5 while busy → no second generation. reset at T+10 → next cycle: all enables 0, generation=0, select=0, busy=0; no write strobe thereafter.
6. GEN_WIDTH=2, 5 generations → generation sequence 1,2,3,0,1. WRITE_LATENCY=3 → first write at T+3, period 40 cycles.
